// File: rtl/if_stage_if.sv
//------------------------------------------------------------------------------
// if_stage_if : fetch-stage bus bundle (imem req/gnt/rvalid, redirect, decode)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int INST_WIDTH   = 32,
   parameter int OPCODE_WIDTH = 7
);
   // instruction memory
   logic                    imem_req;
   logic [ADDR_WIDTH-1:0]   imem_addr;
   logic                    imem_gnt;
   logic                    imem_rvalid;
   logic [INST_WIDTH-1:0]   imem_rdata;
   // redirect from execute
   logic                    redirect_valid;
   logic [ADDR_WIDTH-1:0]   redirect_pc;
   // decode handshake
   logic                    id_ready;
   logic                    inst_valid;
   logic [INST_WIDTH-1:0]   inst;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [ADDR_WIDTH-1:0]   pc_out;
   logic [31:0]             issue_count;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, opcode, pc_out, issue_count,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, opcode, pc_out, issue_count,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// if_stage : instruction fetch stage, one outstanding imem request, redirectable
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          ADDR_WIDTH   = 32,
   parameter int          INST_WIDTH   = 32,
   parameter int          OPCODE_WIDTH = 7
) (
   input  wire          clk,
   input  wire          rst_n,
   if_stage_if.master   bus
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_drop;
   logic [INST_WIDTH-1:0] r_inst;
   logic [ADDR_WIDTH-1:0] r_pc_out;
   logic [31:0]           r_issue_count;

   // Redirect targets are word aligned; the low bits are read but masked off.
   logic [ADDR_WIDTH-1:0] w_redirect_tgt;
   assign w_redirect_tgt = {bus.redirect_pc[ADDR_WIDTH-1:2], bus.redirect_pc[1:0] & 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_BOOT;
         r_pc          <= ADDR_WIDTH'(RESET_PC);
         r_drop        <= 1'b0;
         r_inst        <= '0;
         r_pc_out      <= '0;
         r_issue_count <= 32'd0;
      end else begin
         case (r_state)
            S_BOOT: begin
               if (bus.redirect_valid) r_pc <= w_redirect_tgt;
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (bus.redirect_valid) r_pc <= w_redirect_tgt;
               if (bus.imem_gnt) begin
                  r_drop  <= bus.redirect_valid;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.redirect_valid) r_pc <= w_redirect_tgt;
               if (bus.imem_rvalid) begin
                  // A redirect seen before or with the response invalidates it.
                  if (r_drop || bus.redirect_valid) begin
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end else begin
                     r_inst   <= bus.imem_rdata;
                     r_pc_out <= r_pc;
                     r_state  <= S_ISSUE;
                  end
               end else if (bus.redirect_valid) begin
                  r_drop <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (bus.id_ready) r_issue_count <= r_issue_count + 32'd1;
               if (bus.redirect_valid) begin
                  r_pc    <= w_redirect_tgt;
                  r_state <= S_REQ;
               end else if (bus.id_ready) begin
                  r_pc    <= r_pc + ADDR_WIDTH'(4);
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign bus.imem_req    = (r_state == S_REQ);
   assign bus.imem_addr   = r_pc;
   assign bus.inst_valid  = (r_state == S_ISSUE);
   assign bus.inst        = r_inst;
   assign bus.opcode      = r_inst[OPCODE_WIDTH-1:0];
   assign bus.pc_out      = r_pc_out;
   assign bus.issue_count = r_issue_count;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// tb_if_stage : directed stimulus with a queue-based scoreboard for if_stage
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

   logic clk;
   logic rst_n;

   if_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .OPCODE_WIDTH(7)) bus ();

   if_stage #(
      .RESET_PC    (32'h0000_0000),
      .ADDR_WIDTH  (32),
      .INST_WIDTH  (32),
      .OPCODE_WIDTH(7)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every instruction consumed by decode must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.inst_valid && bus.id_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue_pc", bus.pc_out, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_inst",   bus.inst,   e.inst);
            chk("sb_opcode", 32'(bus.opcode), {25'd0, e.inst[6:0]});
            chk("sb_pc",     bus.pc_out, e.pc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_timeout", 32'(bus.imem_req), 32'd1);
   endtask

   task automatic fetch(input logic [31:0] data, input int lat, input logic [31:0] exp_addr);
      wait_req();
      chk("fetch_addr", bus.imem_addr, exp_addr);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      repeat (lat - 1) tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      tick();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   32'(bus.imem_req),   32'd0);
      chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      chk({tag, "_inst"},  bus.inst,            32'd0);
      chk({tag, "_pcout"}, bus.pc_out,          32'd0);
      chk({tag, "_cnt"},   bus.issue_count,     32'd0);
      chk({tag, "_addr"},  bus.imem_addr,       32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n              = 1'b0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;

      // Reset values, then BOOT for one cycle before the first request
      tick(); tick();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      #1;
      chk("boot_noreq", 32'(bus.imem_req), 32'd0);
      tick();
      chk("first_req", 32'(bus.imem_req), 32'd1);

      // Basic fetch and issue
      exp_q.push_back('{32'h0050_0093, 32'h0});
      fetch(32'h0050_0093, 1, 32'h0);
      chk("t1_valid",  32'(bus.inst_valid), 32'd1);
      chk("t1_opcode", 32'(bus.opcode),     32'h13);
      chk("t1_pcout",  bus.pc_out,          32'h0);
      tick();
      chk("t1_cnt",  bus.issue_count, 32'd1);
      chk("t1_next", bus.imem_addr,   32'h4);

      // Backpressure holds the instruction and blocks new requests
      bus.id_ready = 1'b0;
      exp_q.push_back('{32'h00A0_0113, 32'h4});
      fetch(32'h00A0_0113, 1, 32'h4);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.inst_valid), 32'd1);
         chk("bp_inst",  bus.inst,            32'h00A0_0113);
         chk("bp_pcout", bus.pc_out,          32'h4);
         chk("bp_noreq", 32'(bus.imem_req),   32'd0);
         chk("bp_pc",    bus.imem_addr,       32'h4);
         tick();
      end
      bus.id_ready = 1'b1;
      tick();
      chk("bp_next", bus.imem_addr,   32'h8);
      chk("bp_cnt",  bus.issue_count, 32'd2);

      // Redirect while waiting: late response is discarded
      wait_req();
      chk("w_addr", bus.imem_addr, 32'h8);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      tick();
      bus.redirect_valid = 1'b0;
      chk("w_redir_pc", bus.imem_addr, 32'h100);
      chk("w_noreq",    32'(bus.imem_req), 32'd0);
      tick(); tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rvalid = 1'b0;
      chk("w_novalid", 32'(bus.inst_valid), 32'd0);
      chk("w_req",     32'(bus.imem_req),   32'd1);
      exp_q.push_back('{32'h1234_50B7, 32'h100});
      fetch(32'h1234_50B7, 1, 32'h100);
      chk("w_opcode", 32'(bus.opcode), 32'h37);

      // Redirect in ISSUE together with id_ready
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      tick();
      bus.redirect_valid = 1'b0;
      chk("i_cnt",     bus.issue_count,     32'd3);
      chk("i_addr",    bus.imem_addr,       32'h200);
      chk("i_novalid", 32'(bus.inst_valid), 32'd0);

      // Redirect in REQ on the same cycle as gnt
      wait_req();
      chk("r_addr", bus.imem_addr, 32'h200);
      bus.imem_gnt       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0302;
      tick();
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b0;
      chk("r_redir_pc", bus.imem_addr, 32'h300);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hFFFF_FFFF;
      tick();
      bus.imem_rvalid = 1'b0;
      chk("r_novalid", 32'(bus.inst_valid), 32'd0);
      exp_q.push_back('{32'h0020_8463, 32'h300});
      fetch(32'h0020_8463, 1, 32'h300);
      tick();
      chk("r_cnt",  bus.issue_count, 32'd4);
      chk("r_next", bus.imem_addr,   32'h304);

      // Reset in WAIT, then a stale response in REQ
      wait_req();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("arst");
      tick();
      rst_n = 1'b1;
      tick();
      chk("s_req", 32'(bus.imem_req), 32'd1);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hCAFE_BABE;
      tick();
      bus.imem_rvalid = 1'b0;
      chk("s_req2",    32'(bus.imem_req),   32'd1);
      chk("s_novalid", 32'(bus.inst_valid), 32'd0);
      chk("s_addr",    bus.imem_addr,       32'h0);
      exp_q.push_back('{32'h0050_0093, 32'h0});
      fetch(32'h0050_0093, 1, 32'h0);
      tick();
      chk("s_cnt",  bus.issue_count, 32'd1);
      chk("s_next", bus.imem_addr,   32'h4);

      tick();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
